md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- E-stage sequencer for the multiply/divide unit of the pipelined CPU.
- Issues single-cycle Start pulses and the op code to the MD unit, and tracks its latency with a local countdown.
- Stalls the D stage when an MD-class instruction (mult/div/madd/mfhi/mflo/mthi/mtlo) would collide with a running operation.
- Flags illegal E-stage MD issue while busy.

Parameters:
- MULT_LAT, 5, busy cycles after Start for mult/multu/madd (1..15).
- DIV_LAT, 10, busy cycles after Start for div/divu (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- d_md_use  input  1  D-stage instruction is MD-class.
- e_md_valid  input  1  E-stage holds a valid MD-class instruction.
- e_md_op  input  3  E-stage MD op: 000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo, 110 madd, 111 mfhi/mflo (read).
- flush  input  1  E-stage instruction is killed this cycle.
- md_start  output  1  Start pulse to the MD unit.
- md_op  output  3  op code to the MD unit.
- busy  output  1  MD unit is occupied (running, or starting this cycle).
- remain  output  4  remaining busy cycles.
- stall_d  output  1  freeze the F/D registers and bubble E.
- op_err  output  1  sticky illegal-issue flag.

Behaviour:
- States: IDLE, RUN. Internal register cnt[3:0]. Reset values: state=IDLE, cnt=0, op_err=0. Combinational outputs during reset follow the equations below with state=IDLE.
- issue = e_md_valid & ~flush & (state==IDLE).
- is_start_op: e_md_op in {000,001,010,011}, plus 110 when the optional feature is enabled.
- md_start = issue & is_start_op. Combinational, asserted in the same cycle as the instruction is in E.
- md_op = e_md_op when issue, else 3'b111. 111 with md_start=0 is a no-op for the MD unit, so mthi/mtlo (100/101) reach the MD unit only when issued.
- IDLE -> RUN on md_start:
  - cnt <= MULT_LAT for ops 000/001/110.
  - cnt <= DIV_LAT for ops 010/011.
- RUN: cnt <= cnt-1 each cycle. When cnt==1: next state=IDLE, cnt<=0.
- A Start on cycle T therefore holds busy for cycles T..T+LAT. The first cycle in which a new issue can occur is T+LAT+1.
- busy = (state==RUN) | md_start. remain = cnt.
- stall_d = d_md_use & busy. Stall is combinational; non-MD instructions in D never stall.
- Illegal issue: e_md_valid & ~flush & (state==RUN).
  - Sets op_err (sticky until reset).
  - No Start is issued, md_op=111, and cnt/state are unaffected.
- Illegal op without the feature: op 110 with issue. Sets op_err, md_start=0, state stays IDLE.
- Flush and the running operation:
  - flush never cancels a running operation. The MD unit has already committed, so the countdown continues.
  - flush in the same cycle as a would-be issue suppresses both md_start and md_op.
- Reset mid-RUN: state=IDLE and cnt=0 at the next edge. busy drops in the following cycle.
- Reads (111) in IDLE: md_op=111, md_start=0, no state change.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: op 110 (madd) is a start op using MULT_LAT.
- Undefined: op 110 is illegal (op_err set, no Start); all other behaviour is identical.

Test Plan:
- Reset, then e_md_valid=1, e_md_op=001 for 1 cycle -> md_start=1, md_op=001 that cycle; busy=1 for 6 cycles total; remain 5,4,3,2,1,0; state IDLE after.
- divu (010) issued; d_md_use=1 held -> stall_d=1 for 11 cycles (issue cycle + 10), 0 on the 12th; md_start occurs exactly once.
- mult issued, then e_md_valid=1, e_md_op=111 two cycles later (forced) -> op_err=1 stays set, md_start=0, md_op=111, remain keeps decrementing 3,2,...
- e_md_valid=1, e_md_op=011 with flush=1 -> md_start=0, md_op=111, busy=0; mthi (100) without flush -> md_op=100, md_start=0, busy=0.
- div issued; reset asserted at remain=6 -> next cycle state=IDLE, remain=0, busy=0, op_err=0.
- op 110 issued: with MD_MADD_EN -> md_start=1, remain=5 next cycle; without -> op_err=1, md_start=0.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage sequencer for the multiply/divide unit.
// Issues single-cycle Start pulses and op codes to the MD unit and tracks its
// latency with a local countdown. It stalls D while the unit is occupied and
// latches a sticky error on an illegal issue.
// Optional feature macro: MD_MADD_EN. When it is defined, op 110 (madd) starts
// a multiply-latency operation. When it is not defined, op 110 is illegal.
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_md_use,
  input  logic       e_md_valid,
  input  logic [2:0] e_md_op,
  input  logic       flush,
  output logic       md_start,
  output logic [2:0] md_op,
  output logic       busy,
  output logic [3:0] remain,
  output logic       stall_d,
  output logic       op_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);
  localparam logic [2:0] OP_READ  = 3'b111;
  localparam logic [2:0] OP_MADD  = 3'b110;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       op_err_q, op_err_d;

  logic       e_live;
  logic       issue;
  logic       is_start_op;
  logic       is_div_op;
  logic       madd_illegal;
  logic       run_illegal;

  // Decode the E-stage instruction into issue, start and error conditions.
  always_comb begin
    e_live      = e_md_valid & ~flush;
    issue       = e_live & (state_q == IDLE);
    run_illegal = e_live & (state_q == RUN);
    is_div_op   = (e_md_op == 3'b010) | (e_md_op == 3'b011);
`ifdef MD_MADD_EN
    is_start_op  = ~e_md_op[2] | (e_md_op == OP_MADD);
    madd_illegal = 1'b0;
`else
    is_start_op  = ~e_md_op[2];
    madd_illegal = issue & (e_md_op == OP_MADD);
`endif
  end

  // Drive the MD unit and the pipeline-facing outputs.
  always_comb begin
    md_start = issue & is_start_op;
    md_op    = issue ? e_md_op : OP_READ;
    busy     = (state_q == RUN) | md_start;
    remain   = cnt_q;
    stall_d  = d_md_use & busy;
    op_err   = op_err_q;
  end

  // Next-state logic: load the latency on Start, then count down to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_err_d = op_err_q | run_illegal | madd_illegal;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = RUN;
          cnt_d   = is_div_op ? DIV_CNT : MULT_CNT;
        end
      end
      RUN: begin
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, countdown and sticky error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_err_q <= op_err_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed self-checking bench for md_issue_ctrl.
// The expected values are hand-computed for MULT_LAT=5 and DIV_LAT=10.
// The madd check follows MD_MADD_EN.
module tb_md_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       d_md_use;
  logic       e_md_valid;
  logic [2:0] e_md_op;
  logic       flush;
  logic       md_start;
  logic [2:0] md_op;
  logic       busy;
  logic [3:0] remain;
  logic       stall_d;
  logic       op_err;

  int checkCount;
  int passCount;
  int stallCount;
  int startCount;

  md_issue_ctrl #(
    .MULT_LAT(5),
    .DIV_LAT (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_md_use  (d_md_use),
    .e_md_valid(e_md_valid),
    .e_md_op   (e_md_op),
    .flush     (flush),
    .md_start  (md_start),
    .md_op     (md_op),
    .busy      (busy),
    .remain    (remain),
    .stall_d   (stall_d),
    .op_err    (op_err)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  // Drive the D/E-stage inputs for the current cycle.
  task automatic applyStimulus(input logic d_use, input logic valid, input logic [2:0] op, input logic fl);
    d_md_use   = d_use;
    e_md_valid = valid;
    e_md_op    = op;
    flush      = fl;
  endtask

  // Move to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_remain", 8'(remain), 8'd0);
    checkOutput("rst_op_err", 8'(op_err), 8'd0);
    checkOutput("rst_md_op", 8'(md_op), 8'd7);
    checkOutput("rst_md_start", 8'(md_start), 8'd0);

    // Issue mult and expect six busy cycles.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
    #1;
    checkOutput("mult_start", 8'(md_start), 8'd1);
    checkOutput("mult_md_op", 8'(md_op), 8'd1);
    checkOutput("mult_busy0", 8'(busy), 8'd1);
    checkOutput("mult_nostall", 8'(stall_d), 8'd0);
    for (int i = 1; i <= 5; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      #1;
      checkOutput("mult_busy", 8'(busy), 8'd1);
      checkOutput("mult_remain", 8'(remain), 8'(6 - i));
      checkOutput("mult_nostart", 8'(md_start), 8'd0);
    end
    nextCycle();
    #1;
    checkOutput("mult_done_busy", 8'(busy), 8'd0);
    checkOutput("mult_done_remain", 8'(remain), 8'd0);

    // Issue divu while the D stage holds an MD instruction for the whole window.
    stallCount = 0;
    startCount = 0;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0);
    #1;
    if (stall_d) stallCount++;
    if (md_start) startCount++;
    for (int i = 1; i <= 10; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
      #1;
      if (stall_d) stallCount++;
      if (md_start) startCount++;
      if (i == 1) checkOutput("divu_remain1", 8'(remain), 8'd10);
    end
    nextCycle();
    #1;
    checkOutput("divu_stall_cnt", 8'(stallCount), 8'd11);
    checkOutput("divu_start_cnt", 8'(startCount), 8'd1);
    checkOutput("divu_stall_end", 8'(stall_d), 8'd0);
    checkOutput("divu_op_err", 8'(op_err), 8'd0);

    // Attempt an illegal read while a mult is running.
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 3'b111, 1'b0);
    #1;
    checkOutput("ill_start", 8'(md_start), 8'd0);
    checkOutput("ill_md_op", 8'(md_op), 8'd7);
    checkOutput("ill_remain", 8'(remain), 8'd4);
    checkOutput("ill_err_pre", 8'(op_err), 8'd0);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      #1;
      checkOutput("ill_err", 8'(op_err), 8'd1);
      checkOutput("ill_remain_dec", 8'(remain), 8'(3 - i));
    end
    nextCycle();
    nextCycle();
    nextCycle();
    #1;
    checkOutput("ill_idle_busy", 8'(busy), 8'd0);
    checkOutput("ill_err_sticky", 8'(op_err), 8'd1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("ill_err_clear", 8'(op_err), 8'd0);

    // A flushed div produces no start and no op.
    applyStimulus(1'b0, 1'b1, 3'b011, 1'b1);
    #1;
    checkOutput("flush_start", 8'(md_start), 8'd0);
    checkOutput("flush_md_op", 8'(md_op), 8'd7);
    checkOutput("flush_busy", 8'(busy), 8'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 3'b100, 1'b0);
    #1;
    checkOutput("flush_after_remain", 8'(remain), 8'd0);
    checkOutput("mthi_md_op", 8'(md_op), 8'd4);
    checkOutput("mthi_start", 8'(md_start), 8'd0);
    checkOutput("mthi_busy", 8'(busy), 8'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 3'b111, 1'b0);
    #1;
    checkOutput("mthi_err", 8'(op_err), 8'd0);
    checkOutput("read_md_op", 8'(md_op), 8'd7);
    checkOutput("read_busy", 8'(busy), 8'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("read_remain", 8'(remain), 8'd0);
    checkOutput("read_err", 8'(op_err), 8'd0);

    // Issue div, then apply reset when remain reaches 6.
    applyStimulus(1'b0, 1'b1, 3'b011, 1'b0);
    #1;
    checkOutput("div_start", 8'(md_start), 8'd1);
    for (int i = 1; i <= 5; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    end
    reset = 1'b1;
    #1;
    checkOutput("div_remain6", 8'(remain), 8'd6);
    checkOutput("div_busy_in_rst", 8'(busy), 8'd1);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("div_rst_remain", 8'(remain), 8'd0);
    checkOutput("div_rst_busy", 8'(busy), 8'd0);
    checkOutput("div_rst_err", 8'(op_err), 8'd0);

    // Issue madd: legal only when the optional feature is built in.
    applyStimulus(1'b0, 1'b1, 3'b110, 1'b0);
    #1;
    checkOutput("madd_md_op", 8'(md_op), 8'd6);
`ifdef MD_MADD_EN
    checkOutput("madd_start", 8'(md_start), 8'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("madd_remain", 8'(remain), 8'd5);
    checkOutput("madd_err", 8'(op_err), 8'd0);
`else
    checkOutput("madd_start", 8'(md_start), 8'd0);
    checkOutput("madd_busy", 8'(busy), 8'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("madd_err", 8'(op_err), 8'd1);
    checkOutput("madd_remain", 8'(remain), 8'd0);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
